// File: rtl/lmac_chk_pkg.sv
// Shared definitions for the LMAC RX AXI-Stream frame checker.
// Holds the FSM state encoding, err_code bit positions and the stall phase.
package lmac_chk_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_e;

    localparam int ERR_USER = 0;
    localparam int ERR_DATA = 1;
    localparam int ERR_STRB = 2;
    localparam int ERR_LEN  = 3;

    localparam logic [1:0] STALL_PHASE = 2'd3;

endpackage

// File: rtl/axis_beat_check.sv
// Combinational per-beat checker: byte popcount, strobe shape and payload pattern.
// In: tdata, tstrb, tlast, base byte, lane-0 byte index. Out: popcnt, strobe_ok, data_ok.
module axis_beat_check (
    input  logic [63:0] tdata,
    input  logic [7:0]  tstrb,
    input  logic        tlast,
    input  logic [7:0]  base,
    input  logic [7:0]  byte_idx,
    output logic [3:0]  popcnt,
    output logic        strobe_ok,
    output logic        data_ok
);

    always_comb begin
        popcnt  = '0;
        data_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            popcnt = popcnt + {3'b000, tstrb[i]};
            if (tstrb[i] &&
                tdata[8*i +: 8] != 8'(base + byte_idx + 8'(i)))
                data_ok = 1'b0;
        end
        // A last beat must be a contiguous low-aligned mask (2^k-1, k>0).
        if (tlast)
            strobe_ok = (tstrb != 8'h00) &&
                        ((tstrb & 8'(tstrb + 8'd1)) == 8'h00);
        else
            strobe_ok = (tstrb == 8'hFF);
    end

endmodule

// File: rtl/axis_rx_frame_checker.sv
// RX AXI-Stream consumer: applies tready backpressure, checks each frame
// and keeps frame/byte/error statistics plus the last MAC stats vector.
// In: rx_axis_mac_* stream, stats vector, mode/clear controls.
// Out: tready, frame_done/frame_ok/err_code/last_len, counters, last_stat_vec.
module axis_rx_frame_checker
    import lmac_chk_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int MIN_LEN    = 60,
    parameter int MAX_LEN    = 1518
) (
    input  logic                    rx_mac_aclk,
    input  logic                    reset_,
    input  logic [DATA_WIDTH-1:0]   rx_axis_mac_tdata,
    input  logic                    rx_axis_mac_tvalid,
    input  logic                    rx_axis_mac_tlast,
    input  logic                    rx_axis_mac_tuser,
    input  logic [DATA_WIDTH/8-1:0] rx_axis_mac_tstrb,
    output logic                    rx_axis_mac_tready,
    input  logic [27:0]             rx_statistics_vector,
    input  logic                    rx_statistics_valid,
    input  logic                    rx_axis_compatible_mode,
    input  logic                    stall_en,
    input  logic                    check_en,
    input  logic                    clr_stats,
    output logic                    frame_done,
    output logic                    frame_ok,
    output logic [3:0]              err_code,
    output logic [15:0]             last_len,
    output logic [31:0]             frame_cnt,
    output logic [15:0]             err_cnt,
    output logic [31:0]             byte_cnt,
    output logic [27:0]             last_stat_vec
);

    localparam logic [15:0] MIN_L = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L = 16'(MAX_LEN);

    state_e      state_q, state_d;
    logic [1:0]  stall_q, stall_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  base_q, base_d;
    logic [3:0]  err_q, err_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_ok_q, frame_ok_d;
    logic [3:0]  err_code_q, err_code_d;
    logic [15:0] last_len_q, last_len_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [27:0] stat_q, stat_d;

    logic        accept;
    logic        first;
    logic [15:0] cur_len;
    logic [7:0]  cur_idx;
    logic [7:0]  cur_base;
    logic [3:0]  beat_err;
    logic [3:0]  end_err;
    logic [16:0] sum;
    logic [15:0] new_len;
    logic [3:0]  popcnt;
    logic        strobe_ok;
    logic        data_ok;

    assign rx_axis_mac_tready = rx_axis_compatible_mode | ~stall_en |
                                (stall_q != STALL_PHASE);

    // A first beat uses fresh accumulators and the live frame count as base.
    assign first    = (state_q == IDLE);
    assign cur_len  = first ? 16'd0 : len_q;
    assign cur_idx  = first ? 8'd0 : idx_q;
    assign cur_base = first ? frame_cnt_q[7:0] : base_q;

    axis_beat_check u_beat (
        .tdata     (rx_axis_mac_tdata),
        .tstrb     (rx_axis_mac_tstrb),
        .tlast     (rx_axis_mac_tlast),
        .base      (cur_base),
        .byte_idx  (cur_idx),
        .popcnt    (popcnt),
        .strobe_ok (strobe_ok),
        .data_ok   (data_ok)
    );

    always_comb begin
        accept  = rx_axis_mac_tvalid & rx_axis_mac_tready;
        sum     = {1'b0, cur_len} + {13'd0, popcnt};
        new_len = sum[16] ? 16'hFFFF : sum[15:0];

        beat_err = first ? 4'd0 : err_q;
        beat_err[ERR_STRB] = beat_err[ERR_STRB] | ~strobe_ok;
        beat_err[ERR_DATA] = beat_err[ERR_DATA] | (check_en & ~data_ok);

        end_err = beat_err;
        end_err[ERR_LEN]  = (new_len < MIN_L) || (new_len > MAX_L);
        end_err[ERR_USER] = rx_axis_mac_tuser;

        state_d      = state_q;
        stall_d      = stall_q + 2'd1;
        len_d        = len_q;
        idx_d        = idx_q;
        base_d       = base_q;
        err_d        = err_q;
        frame_done_d = 1'b0;
        frame_ok_d   = frame_ok_q;
        err_code_d   = err_code_q;
        last_len_d   = last_len_q;
        frame_cnt_d  = frame_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        err_cnt_d    = err_cnt_q;
        stat_d       = rx_statistics_valid ? rx_statistics_vector : stat_q;

        if (accept) begin
            len_d  = new_len;
            idx_d  = cur_idx + 8'd8;
            base_d = cur_base;
            err_d  = beat_err;
            if (rx_axis_mac_tlast) begin
                state_d      = IDLE;
                frame_done_d = 1'b1;
                frame_ok_d   = (end_err == 4'd0);
                err_code_d   = end_err;
                last_len_d   = new_len;
                frame_cnt_d  = frame_cnt_q + 32'd1;
                if (end_err == 4'd0)
                    byte_cnt_d = byte_cnt_q + {16'd0, new_len};
                else if (err_cnt_q != 16'hFFFF)
                    err_cnt_d = err_cnt_q + 16'd1;
            end else begin
                state_d = FRAME;
            end
        end

        // Clear dominates any same-cycle frame end or stats capture.
        if (clr_stats) begin
            state_d      = IDLE;
            frame_done_d = 1'b0;
            frame_ok_d   = 1'b0;
            err_code_d   = '0;
            last_len_d   = '0;
            frame_cnt_d  = '0;
            byte_cnt_d   = '0;
            err_cnt_d    = '0;
            stat_d       = '0;
        end
    end

    always_ff @(posedge rx_mac_aclk or negedge reset_) begin
        if (!reset_) begin
            state_q      <= IDLE;
            stall_q      <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            base_q       <= '0;
            err_q        <= '0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            err_code_q   <= '0;
            last_len_q   <= '0;
            frame_cnt_q  <= '0;
            byte_cnt_q   <= '0;
            err_cnt_q    <= '0;
            stat_q       <= '0;
        end else begin
            state_q      <= state_d;
            stall_q      <= stall_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            base_q       <= base_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            err_code_q   <= err_code_d;
            last_len_q   <= last_len_d;
            frame_cnt_q  <= frame_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            err_cnt_q    <= err_cnt_d;
            stat_q       <= stat_d;
        end
    end

    assign frame_done    = frame_done_q;
    assign frame_ok      = frame_ok_q;
    assign err_code      = err_code_q;
    assign last_len      = last_len_q;
    assign frame_cnt     = frame_cnt_q;
    assign byte_cnt      = byte_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign last_stat_vec = stat_q;

endmodule
